// File: rtl/focal_delay_calc_pkg.sv
// Shared beamforming constants and state encoding for the focal delay
// calculator and the square-root unit it drives.
//   - state_t        : controller state encoding
//   - COORD_W_DEF    : default coordinate width
//   - ROOT_ITERS     : Newton iterations performed by the root unit
//   - ROOT_LATENCY   : approximate enabled cycles until the root unit is valid
//   - MIN_TIMEOUT    : smallest sensible root-valid timeout
//   - SQ_DIN_W/SQ_DOUT_W : root-unit bus widths
package focal_delay_calc_pkg;

  localparam int COORD_W_DEF       = 8;
  localparam int ROOT_ITERS        = 11;
  localparam int ROOT_CYC_PER_ITER = 5;
  localparam int ROOT_LATENCY      = ROOT_ITERS * ROOT_CYC_PER_ITER + 2;
  // Next power of two above the root latency leaves headroom for the timeout.
  localparam int MIN_TIMEOUT       = 2 ** $clog2(ROOT_LATENCY);

  localparam int SQ_DIN_W  = 32;
  localparam int SQ_DOUT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    SUM,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/focal_delay_calc_if.sv
// Bus between the delay calculator (master) and the iterative square-root
// unit (slave).
//   sq_din    : radicand, master -> slave
//   sq_enable : root-unit clock enable, master -> slave
//   sq_reset  : root-unit restart (active high), master -> slave
//   sq_dout   : root result, slave -> master
//   sq_valid  : root result valid (level), slave -> master
interface focal_delay_calc_if;
  import focal_delay_calc_pkg::*;

  logic [SQ_DIN_W-1:0]  sq_din;
  logic                 sq_enable;
  logic                 sq_reset;
  logic [SQ_DOUT_W-1:0] sq_dout;
  logic                 sq_valid;

  modport master (
    output sq_din, sq_enable, sq_reset,
    input  sq_dout, sq_valid
  );

  modport slave (
    input  sq_din, sq_enable, sq_reset,
    output sq_dout, sq_valid
  );

endinterface

// File: rtl/focal_delay_calc.sv
// Beamforming receive-delay front end. For one element/focal-point pair it
// forms dx^2 + z^2, has the external square-root unit take its root, and
// returns the two-way path length sqrt + z.
// Ports:
//   clk, reset : clock (rising edge), asynchronous active-high reset
//   start      : request pulse, honoured in IDLE only
//   dx         : signed lateral offset, COORD_W+1 bits
//   z          : unsigned focal depth, COORD_W bits
//   busy       : job in progress
//   done       : one-cycle completion pulse
//   err        : root-unit timeout flag, valid with done
//   delay      : path length r + z, held until the next done
//   sq         : master side of the square-root unit bus
module focal_delay_calc
  import focal_delay_calc_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int TIMEOUT = 128,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic signed [COORD_W:0]   dx,
  input  logic        [COORD_W-1:0] z,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic        [COORD_W+8:0] delay,
  focal_delay_calc_if.master        sq
);

  localparam int SQ_W  = 2 * COORD_W;
  localparam int SUM_W = 2 * COORD_W + 1;
  localparam int DLY_W = COORD_W + 9;
  // The counter holds completed WAIT cycles; the last one is TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t state, state_next;

  logic        [CNT_W-1:0]     cnt;
  logic signed [COORD_W:0]     dx_p0;
  logic        [COORD_W-1:0]   z_p0;
  logic        [COORD_W-1:0]   adx;
  logic        [SQ_W-1:0]      dx2_p1;
  logic        [SQ_W-1:0]      z2_p1;
  logic        [SUM_W-1:0]     sum;
  logic        [SQ_DOUT_W-1:0] r_p2;
  logic                        bypass;
  logic                        timeout;

  // |v|, with the single unrepresentable magnitude -2^COORD_W clamped.
  function automatic logic [COORD_W-1:0] abs_sat(input logic signed [COORD_W:0] v);
    logic signed [COORD_W:0] mag;
    mag = v[COORD_W] ? -v : v;
    if (v == {1'b1, {COORD_W{1'b0}}})
      return {COORD_W{1'b1}};
    return mag[COORD_W-1:0];
  endfunction

  assign adx     = abs_sat(dx_p0);
  assign sum     = SUM_W'(dx2_p1) + SUM_W'(z2_p1);
  // The root unit divides by din>>1, so radicands 0 and 1 are their own root.
  assign bypass  = (sum < SUM_W'(2));
  assign timeout = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = MUL;
      MUL:  state_next = SUM;
      SUM:  state_next = bypass ? DONE : WAIT;
      WAIT: if (sq.sq_valid || timeout) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stage p0: operand capture on accepted start.
  // Stage p1: squares.  Stage p2: root result (or bypass value).
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (start) begin
        dx_p0 <= dx;
        z_p0  <= z;
      end
      MUL: begin
        dx2_p1 <= SQ_W'(adx) * SQ_W'(adx);
        z2_p1  <= SQ_W'(z_p0) * SQ_W'(z_p0);
      end
      SUM: if (bypass) r_p2 <= SQ_DOUT_W'(sum);
      WAIT: begin
        if (sq.sq_valid)  r_p2 <= sq.sq_dout;
        else if (timeout) r_p2 <= '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      delay        <= '0;
      cnt          <= '0;
      sq.sq_din    <= '0;
      sq.sq_enable <= 1'b0;
      sq.sq_reset  <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          err  <= 1'b0;
        end
        SUM: begin
          // din is written only here, so it stays put while the root iterates.
          sq.sq_din <= SQ_DIN_W'(sum);
          if (!bypass) begin
            sq.sq_reset  <= 1'b0;
            sq.sq_enable <= 1'b1;
          end
        end
        WAIT: begin
          if (!sq.sq_valid) begin
            if (timeout) err <= 1'b1;
            else         cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          delay        <= err ? '0 : DLY_W'(r_p2) + DLY_W'(z_p0);
          done         <= 1'b1;
          busy         <= 1'b0;
          cnt          <= '0;
          sq.sq_reset  <= 1'b1;
          sq.sq_enable <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_focal_delay_calc.sv
// Bench for focal_delay_calc. A behavioural square-root responder answers
// with floor(sqrt(din)) a fixed number of enabled cycles after it is
// released from reset.
module tb_focal_delay_calc;
  import focal_delay_calc_pkg::*;

  localparam int CW  = 8;
  localparam int TO  = 128;
  localparam int LAT = ROOT_LATENCY;

  typedef struct {
    logic signed [CW:0]   dx;
    logic        [CW-1:0] z;
    logic        [31:0]   din;
    logic                 bypass;
    logic        [CW+8:0] delay;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic signed [CW:0]   dx = '0;
  logic        [CW-1:0] z = '0;
  logic                 busy, done, err;
  logic        [CW+8:0] delay;
  logic                 valid_en = 1'b1;
  int                   mcnt = 0;
  int                   checks = 0;
  int                   failures = 0;

  focal_delay_calc_if sq_bus ();

  focal_delay_calc #(.COORD_W(CW), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .dx    (dx),
    .z     (z),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .delay (delay),
    .sq    (sq_bus)
  );

  always #5 clk = ~clk;

  function automatic int unsigned isqrt(input logic [31:0] v);
    int unsigned r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  always @(posedge clk) begin
    if (sq_bus.sq_reset) begin
      mcnt           <= 0;
      sq_bus.sq_valid <= 1'b0;
      sq_bus.sq_dout  <= '0;
    end else if (sq_bus.sq_enable && valid_en) begin
      if (mcnt == LAT - 1) begin
        sq_bus.sq_valid <= 1'b1;
        sq_bus.sq_dout  <= 16'(isqrt(sq_bus.sq_din));
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic launch(input logic signed [CW:0] a, input logic [CW-1:0] b);
    @(negedge clk);
    dx = a;
    z = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done is seen (0 = never).
  task automatic wait_done(output int cyc, output logic en_seen, output logic din_stable);
    logic [31:0] first_din;
    logic have;
    cyc = 0;
    en_seen = 1'b0;
    din_stable = 1'b1;
    have = 1'b0;
    first_din = '0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk);
      #1;
      if (sq_bus.sq_enable) begin
        en_seen = 1'b1;
        if (!have) begin
          first_din = sq_bus.sq_din;
          have = 1'b1;
        end else if (sq_bus.sq_din !== first_din) begin
          din_stable = 1'b0;
        end
      end
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic count_dones(input int n, output int cnt_d);
    cnt_d = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (done) cnt_d++;
    end
  endtask

  vec_t vecs[9];

  initial begin
    int   cyc, cyc2, nd;
    logic en_seen, din_stable;

    vecs[0] = '{dx:  9'sd3,    z: 8'd4,   din: 32'd25,     bypass: 1'b0, delay: 17'd9};
    vecs[1] = '{dx: -9'sd3,    z: 8'd4,   din: 32'd25,     bypass: 1'b0, delay: 17'd9};
    vecs[2] = '{dx: -9'sd256,  z: 8'd4,   din: 32'd65041,  bypass: 1'b0, delay: 17'd259};
    vecs[3] = '{dx:  9'sd0,    z: 8'd0,   din: 32'd0,      bypass: 1'b1, delay: 17'd0};
    vecs[4] = '{dx:  9'sd1,    z: 8'd0,   din: 32'd1,      bypass: 1'b1, delay: 17'd1};
    vecs[5] = '{dx:  9'sd255,  z: 8'd255, din: 32'd130050, bypass: 1'b0, delay: 17'd615};
    vecs[6] = '{dx:  9'sd0,    z: 8'd5,   din: 32'd25,     bypass: 1'b0, delay: 17'd10};
    vecs[7] = '{dx: -9'sd1,    z: 8'd1,   din: 32'd2,      bypass: 1'b0, delay: 17'd2};
    vecs[8] = '{dx: -9'sd255,  z: 8'd0,   din: 32'd65025,  bypass: 1'b0, delay: 17'd255};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_delay", 32'(delay), 32'd0);
    check("rst_sq_din", sq_bus.sq_din, 32'd0);
    check("rst_sq_enable", 32'(sq_bus.sq_enable), 32'd0);
    check("rst_sq_reset", 32'(sq_bus.sq_reset), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      launch(vecs[i].dx, vecs[i].z);
      check($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
      wait_done(cyc, en_seen, din_stable);
      check($sformatf("v%0d_latency", i), 32'(cyc), vecs[i].bypass ? 32'd3 : 32'(LAT + 4));
      check($sformatf("v%0d_sq_din", i), sq_bus.sq_din, vecs[i].din);
      check($sformatf("v%0d_delay", i), 32'(delay), 32'(vecs[i].delay));
      check($sformatf("v%0d_err", i), 32'(err), 32'd0);
      check($sformatf("v%0d_enable_seen", i), 32'(en_seen), 32'(!vecs[i].bypass));
      check($sformatf("v%0d_din_stable", i), 32'(din_stable), 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      check($sformatf("v%0d_idle_busy", i), 32'(busy), 32'd0);
    end

    // Root never answers: timeout path, then recovery.
    valid_en = 1'b0;
    launch(9'sd3, 8'd4);
    wait_done(cyc, en_seen, din_stable);
    check("to_latency", 32'(cyc), 32'(TO + 3));
    check("to_err", 32'(err), 32'd1);
    check("to_delay", 32'(delay), 32'd0);
    check("to_sq_reset", 32'(sq_bus.sq_reset), 32'd1);
    check("to_sq_enable", 32'(sq_bus.sq_enable), 32'd0);
    valid_en = 1'b1;
    launch(9'sd3, 8'd4);
    check("to_err_cleared", 32'(err), 32'd0);
    wait_done(cyc, en_seen, din_stable);
    check("rec_latency", 32'(cyc), 32'(LAT + 4));
    check("rec_err", 32'(err), 32'd0);
    check("rec_delay", 32'(delay), 32'd9);

    // Reset 10 cycles into WAIT aborts without a done.
    launch(9'sd3, 8'd4);
    repeat (12) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_sq_reset", 32'(sq_bus.sq_reset), 32'd1);
    check("mid_rst_sq_enable", 32'(sq_bus.sq_enable), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    count_dones(100, nd);
    check("mid_rst_no_done", 32'(nd), 32'd0);

    // start while busy is ignored.
    launch(9'sd3, 8'd4);
    repeat (20) @(posedge clk);
    @(negedge clk);
    dx = 9'sd0;
    z = 8'd0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc2, en_seen, din_stable);
    check("ign_latency", 32'(cyc2 + 21), 32'(LAT + 4));
    check("ign_delay", 32'(delay), 32'd9);
    count_dones(70, nd);
    check("ign_single_done", 32'(nd), 32'd0);

    // start raised in the done cycle is taken on the following edge.
    launch(9'sd3, 8'd4);
    wait_done(cyc, en_seen, din_stable);
    check("b2b_first_delay", 32'(delay), 32'd9);
    dx = 9'sd0;
    z = 8'd5;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("b2b_accept_busy", 32'(busy), 32'd1);
    check("b2b_sq_reset_gap", 32'(sq_bus.sq_reset), 32'd1);
    wait_done(cyc, en_seen, din_stable);
    check("b2b_latency", 32'(cyc), 32'(LAT + 4));
    check("b2b_delay", 32'(delay), 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
